// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between the edge-event arbiter and its consumer.
// valid/ready rule: the producer raises evt_valid with evt_ch/evt_rising
// stable, and holds all three unchanged until it sees evt_valid & evt_ready
// at a rising clock edge. That edge is the transfer. The consumer may drive
// evt_ready at any time, independently of evt_valid.
interface edge_event_arbiter_if #(
  parameter int CH_W = 2
);
  logic            evt_valid;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rising;
  logic            evt_ready;

  modport master (
    output evt_valid,
    output evt_ch,
    output evt_rising,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_rising,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller.
// Each channel has an edge detector with a selectable polarity. Each channel
// can hold one pending event. A round-robin arbiter sends pending events, one
// at a time, to a single consumer over a valid/ready handshake.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                clk_amisha,
  input  logic                reset_amisha,
  input  logic [NUM_CH-1:0]   level_amisha,
  input  logic [2*NUM_CH-1:0] edge_mode,
  edge_event_arbiter_if.master evt_if,
  output logic [NUM_CH-1:0]   overflow,
  input  logic                ovf_clear,
  output logic                o_dbg_state
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NUM_CH-1:0] r_prev;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_pend_pol;
  logic [NUM_CH-1:0] r_overflow;
  logic [CH_W-1:0]   r_last_grant;
  logic [CH_W-1:0]   r_evt_ch;
  logic              r_evt_rising;

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_drop;
  logic              w_found;
  logic [CH_W-1:0]   w_winner;
  logic              w_grant;

  // Per-channel edge detect. Each edge is then gated by that channel's mode
  // bits: bit 0 enables rising edges, bit 1 enables falling edges.
  always_comb begin
    w_rise = '0;
    w_fall = '0;
    w_tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rise[i] = level_amisha[i] & ~r_prev[i];
      w_fall[i] = ~level_amisha[i] & r_prev[i];
      w_tick[i] = (w_rise[i] & edge_mode[2*i]) | (w_fall[i] & edge_mode[2*i+1]);
    end
  end

  // Round-robin search. It starts one channel past the last grant and wraps.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_CH;
      if (!w_found && r_pending[idx]) begin
        w_found  = 1'b1;
        w_winner = CH_W'(idx);
      end
    end
  end

  // Output FSM next state. A grant may happen from IDLE, or in PRESENT on the
  // same edge as a handshake, so back-to-back events keep valid high.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (evt_if.evt_ready) begin
          if (w_found) begin
            w_grant = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decide, per channel, whether its pending slot is freed by this grant and
  // whether a new tick finds the slot still occupied, which drops the event.
  always_comb begin
    w_clr  = '0;
    w_drop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_clr[i]  = w_grant && (w_winner == CH_W'(i));
      w_drop[i] = w_tick[i] & r_pending[i] & ~w_clr[i];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Delay bits, pending slots and sticky overflow flags. A tick that arrives
  // while its own slot is being granted refills the slot with the new polarity.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_prev     <= '0;
      r_pending  <= '0;
      r_pend_pol <= '0;
      r_overflow <= '0;
    end else begin
      r_prev     <= level_amisha;
      r_overflow <= (ovf_clear ? '0 : r_overflow) | w_drop;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_tick[i] && !w_drop[i]) begin
          r_pending[i]  <= 1'b1;
          r_pend_pol[i] <= w_rise[i];
        end else if (w_clr[i]) begin
          r_pending[i]  <= 1'b0;
        end
      end
    end
  end

  // Output register and round-robin pointer. Both load only on a grant.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_evt_ch     <= '0;
      r_evt_rising <= 1'b0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else if (w_grant) begin
      r_evt_ch     <= w_winner;
      r_evt_rising <= r_pend_pol[w_winner];
      r_last_grant <= w_winner;
    end
  end

  assign evt_if.evt_valid  = (r_state == ST_PRESENT);
  assign evt_if.evt_ch     = r_evt_ch;
  assign evt_if.evt_rising = r_evt_rising;
  assign overflow          = r_overflow;
  assign o_dbg_state       = r_state;

endmodule
